// File: rtl/weight_streamer_pkg.sv
// Shared definitions for the weight streamer: FSM state encoding and a
// ceiling-divide helper used to derive the fold count from the kernel count.
package weight_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/weight_streamer_bank.sv
// weight_bank: one DEPTH x DW weight memory, one write port and one read port.
// The read is registered and the output holds its value when rd_en is low.
// Ports:
//   clk                        clock
//   wr_en, wr_addr, wr_data    write port (preload)
//   rd_en, rd_addr             read request
//   rd_data                    read result, valid the cycle after rd_en
module weight_bank #(
  parameter int DW      = 8,
  parameter int DEPTH   = 256,
  parameter int ADDR_DW = 8
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_DW-1:0] wr_addr,
  input  logic [DW-1:0]      wr_data,
  input  logic               rd_en,
  input  logic [ADDR_DW-1:0] rd_addr,
  output logic [DW-1:0]      rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Contents carry no reset so preloaded weights survive a stream abort.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/weight_streamer.sv
// weight_streamer: streams one layer's kernels out of COLS weight banks, one
// beat per (fold, element). Kernel k lives in bank k mod COLS at address
// base_addr + (k div COLS)*kernel_elem + e (mod DEPTH).
// Ports:
//   clk, rst                          clock, async active-high reset
//   start, kernel_num, kernel_elem,   layer request and its parameters
//   base_addr
//   busy, done                        stream in progress / end-of-stream pulse
//   wr_en, wr_col, wr_addr, wr_data   bank preload (ignored while busy)
//   wr_drop                           sticky: a write was discarded
//   out_valid, out_ready              output handshake
//   out_data, out_mask, out_last,     beat payload, column mask, end of fold,
//   out_fold                          fold index
//
// state  | meaning
// IDLE   | waiting for start; first read issues in the start cycle
// FETCH  | issuing bank reads while FIFO + in-flight leaves room
// DRAIN  | all reads issued, waiting for the FIFO to empty
// FINISH | stream complete; done pulses the following cycle
module weight_streamer
  import weight_streamer_pkg::*;
#(
  parameter int DW      = 8,
  parameter int COLS    = 8,
  parameter int DEPTH   = 256,
  parameter int ADDR_DW = 8,
  parameter int CNT_DW  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_DW-1:0]       kernel_num,
  input  logic [CNT_DW-1:0]       kernel_elem,
  input  logic [ADDR_DW-1:0]      base_addr,
  output logic                    busy,
  output logic                    done,
  input  logic                    wr_en,
  input  logic [$clog2(COLS)-1:0] wr_col,
  input  logic [ADDR_DW-1:0]      wr_addr,
  input  logic [DW-1:0]           wr_data,
  output logic                    wr_drop,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DW*COLS-1:0]      out_data,
  output logic [COLS-1:0]         out_mask,
  output logic                    out_last,
  output logic [CNT_DW-1:0]       out_fold
);

  localparam int COL_W = $clog2(COLS);

  state_t state_q, state_d;

  logic [CNT_DW-1:0]  kn_q, ke_q, nfold_q, elem_q, fold_q, kbase_q;
  logic [ADDR_DW-1:0] fold_addr_q;

  logic               infl_q;
  logic [COLS-1:0]    infl_mask_q;
  logic               infl_last_q;
  logic [CNT_DW-1:0]  infl_fold_q;

  logic [DW*COLS-1:0] fifo_data [2];
  logic [COLS-1:0]    fifo_mask [2];
  logic               fifo_last [2];
  logic [CNT_DW-1:0]  fifo_fold [2];
  logic               wptr_q, rptr_q;
  logic [1:0]         cnt_q;

  logic               done_q, wr_drop_q;

  logic               accept, empty_job, pop, issue, all_issued, elem_end;
  logic [1:0]         occ_after_pop, occ;
  logic [COLS-1:0]    rd_mask, rd_en_col;
  logic [ADDR_DW-1:0] rd_addr;
  logic               rd_last;
  logic [CNT_DW-1:0]  rd_fold, rem;
  logic [DW-1:0]      bank_q [COLS];
  logic [DW*COLS-1:0] rd_beat;

  assign busy          = (state_q != IDLE);
  assign accept        = start && (state_q == IDLE);
  assign empty_job     = (kernel_num == '0) || (kernel_elem == '0);
  assign pop           = out_valid && out_ready;
  assign occ_after_pop = cnt_q - {1'b0, pop};
  // Occupancy counts the slot freed by this cycle's pop so a steady stream
  // with out_ready high keeps one read in flight every cycle.
  assign occ           = occ_after_pop + {1'b0, infl_q};
  assign all_issued    = (fold_q == nfold_q);
  assign elem_end      = (elem_q == ke_q - CNT_DW'(1));

  // Read request: element 0 of fold 0 goes out in the start cycle straight
  // from the inputs, later reads come from the element/fold counters.
  always_comb begin
    rd_addr = fold_addr_q + elem_q[ADDR_DW-1:0];
    rd_last = elem_end;
    rd_fold = fold_q;
    rem     = kn_q - kbase_q;
    issue   = (state_q == FETCH) && !all_issued && (occ < 2'd2);
    if (state_q == IDLE) begin
      rd_addr = base_addr;
      rd_last = (kernel_elem == CNT_DW'(1));
      rd_fold = '0;
      rem     = kernel_num;
      issue   = start && !empty_job;
    end
    for (int c = 0; c < COLS; c++) begin
      rd_mask[c] = (CNT_DW'(c) < rem);
    end
    rd_en_col = rd_mask & {COLS{issue}};
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bank
    weight_bank #(
      .DW      (DW),
      .DEPTH   (DEPTH),
      .ADDR_DW (ADDR_DW)
    ) u_bank (
      .clk     (clk),
      .wr_en   (wr_en && !busy && (wr_col == COL_W'(c))),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en_col[c]),
      .rd_addr (rd_addr),
      .rd_data (bank_q[c])
    );
    // Unread (masked) banks keep stale output, so force those lanes to zero.
    assign rd_beat[c*DW +: DW] = bank_q[c] & {DW{infl_mask_q[c]}};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = empty_job ? FINISH : FETCH;
      FETCH:   if (all_issued) state_d = DRAIN;
      DRAIN:   if (!infl_q && (occ_after_pop == 2'd0)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      wr_drop_q   <= 1'b0;
      kn_q        <= '0;
      ke_q        <= '0;
      nfold_q     <= '0;
      elem_q      <= '0;
      fold_q      <= '0;
      kbase_q     <= '0;
      fold_addr_q <= '0;
      infl_q      <= 1'b0;
      infl_mask_q <= '0;
      infl_last_q <= 1'b0;
      infl_fold_q <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == FINISH);

      if (accept) wr_drop_q <= 1'b0;
      else if (wr_en && busy) wr_drop_q <= 1'b1;

      if (accept) begin
        kn_q    <= kernel_num;
        ke_q    <= kernel_elem;
        nfold_q <= CNT_DW'(ceil_div(32'(kernel_num), 32'(COLS)));
        // Element 0 was already issued this cycle; point at what follows it.
        if (kernel_elem == CNT_DW'(1)) begin
          elem_q      <= '0;
          fold_q      <= CNT_DW'(1);
          fold_addr_q <= base_addr + kernel_elem[ADDR_DW-1:0];
          kbase_q     <= CNT_DW'(COLS);
        end else begin
          elem_q      <= CNT_DW'(1);
          fold_q      <= '0;
          fold_addr_q <= base_addr;
          kbase_q     <= '0;
        end
      end else if (issue) begin
        if (elem_end) begin
          elem_q      <= '0;
          fold_q      <= fold_q + CNT_DW'(1);
          fold_addr_q <= fold_addr_q + ke_q[ADDR_DW-1:0];
          kbase_q     <= kbase_q + CNT_DW'(COLS);
        end else begin
          elem_q <= elem_q + CNT_DW'(1);
        end
      end

      infl_q <= issue;
      if (issue) begin
        infl_mask_q <= rd_mask;
        infl_last_q <= rd_last;
        infl_fold_q <= rd_fold;
      end

      if (infl_q) wptr_q <= ~wptr_q;
      if (pop)    rptr_q <= ~rptr_q;
      cnt_q <= occ;
    end
  end

  always_ff @(posedge clk) begin
    if (infl_q) begin
      fifo_data[wptr_q] <= rd_beat;
      fifo_mask[wptr_q] <= infl_mask_q;
      fifo_last[wptr_q] <= infl_last_q;
      fifo_fold[wptr_q] <= infl_fold_q;
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = out_valid ? fifo_data[rptr_q] : '0;
  assign out_mask  = out_valid ? fifo_mask[rptr_q] : '0;
  assign out_last  = out_valid ? fifo_last[rptr_q] : 1'b0;
  assign out_fold  = out_valid ? fifo_fold[rptr_q] : '0;
  assign done      = done_q;
  assign wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_weight_streamer.sv
module tb_weight_streamer;

  localparam int DW = 8, COLS = 8, DEPTH = 256, ADDR_DW = 8, CNT_DW = 16;

  logic                    clk = 1'b0;
  logic                    rst, start;
  logic [CNT_DW-1:0]       kernel_num, kernel_elem;
  logic [ADDR_DW-1:0]      base_addr;
  logic                    busy, done;
  logic                    wr_en;
  logic [2:0]              wr_col;
  logic [ADDR_DW-1:0]      wr_addr;
  logic [DW-1:0]           wr_data;
  logic                    wr_drop, out_valid, out_ready, out_last;
  logic [DW*COLS-1:0]      out_data;
  logic [COLS-1:0]         out_mask;
  logic [CNT_DW-1:0]       out_fold;

  weight_streamer #(
    .DW(DW), .COLS(COLS), .DEPTH(DEPTH), .ADDR_DW(ADDR_DW), .CNT_DW(CNT_DW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .kernel_num(kernel_num),
    .kernel_elem(kernel_elem), .base_addr(base_addr), .busy(busy), .done(done),
    .wr_en(wr_en), .wr_col(wr_col), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_drop(wr_drop), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mask(out_mask), .out_last(out_last), .out_fold(out_fold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  mask;
    logic        last;
    logic [15:0] fold;
  } beat_t;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    beat_cnt = 0;
  bit    rnd_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int c, input int a);
    int v;
    v = (c * 37 + a * 5 + 1) % 256;
    return 8'(v);
  endfunction

  function automatic int push_expected(input int kn, input int ke, input int base);
    beat_t b;
    int nf, k, a;
    nf = (kn + COLS - 1) / COLS;
    for (int f = 0; f < nf; f++) begin
      for (int e = 0; e < ke; e++) begin
        b.data = '0;
        b.mask = '0;
        for (int c = 0; c < COLS; c++) begin
          k = f * COLS + c;
          if (k < kn) begin
            a = (base + f * ke + e) % DEPTH;
            b.mask[c] = 1'b1;
            b.data[c*DW +: DW] = pat(c, a);
          end
        end
        b.last = (e == ke - 1);
        b.fold = 16'(f);
        sb.push_back(b);
      end
    end
    return nf * ke;
  endfunction

  initial begin : ready_drv
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  initial begin : monitor
    beat_t       eb;
    logic        hold_vld;
    logic [63:0] h_data;
    logic [7:0]  h_mask;
    logic        h_last;
    logic [15:0] h_fold;
    hold_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !out_valid) begin
        hold_vld = 1'b0;
      end else begin
        if (hold_vld) begin
          check("stall_data", out_data, h_data);
          check("stall_mask", 64'(out_mask), 64'(h_mask));
          check("stall_last", 64'(out_last), 64'(h_last));
          check("stall_fold", 64'(out_fold), 64'(h_fold));
        end
        if (out_ready) begin
          hold_vld = 1'b0;
          beat_cnt++;
          if (sb.size() == 0) begin
            check("unexpected_beat_queue_size", 64'(sb.size()), 64'd1);
          end else begin
            eb = sb.pop_front();
            check("beat_data", out_data, eb.data);
            check("beat_mask", 64'(out_mask), 64'(eb.mask));
            check("beat_last", 64'(out_last), 64'(eb.last));
            check("beat_fold", 64'(out_fold), 64'(eb.fold));
          end
        end else begin
          hold_vld = 1'b1;
          h_data = out_data;
          h_mask = out_mask;
          h_last = out_last;
          h_fold = out_fold;
        end
      end
    end
  end

  // Called at posedge+1; start is sampled by the next posedge (cycle 0).
  task automatic run_stream(input int kn, input int ke, input int base,
                            input int exp_first, input int exp_done,
                            input bit hand, input bit poke);
    int cyc, first_v, done_c, b0, nbeats;
    nbeats = push_expected(kn, ke, base);
    b0 = beat_cnt;
    kernel_num = 16'(kn);
    kernel_elem = 16'(ke);
    base_addr = 8'(base);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    first_v = -1;
    done_c = -1;
    while (done_c < 0 && cyc < 3000) begin
      if (poke && cyc == 5) begin
        kernel_num = '0;
        kernel_elem = '0;
        start = 1'b1;
      end
      @(negedge clk);
      if (first_v < 0 && out_valid) begin
        first_v = cyc;
        if (hand) begin
          check("t1_first_col0", 64'(out_data[7:0]), 64'h01);
          check("t1_first_col1", 64'(out_data[15:8]), 64'h26);
          check("t1_first_mask", 64'(out_mask), 64'h3F);
          check("t1_upper_cols_zero", 64'(out_data[63:48]), 64'h0);
        end
      end
      if (done) done_c = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
    check("first_valid_cycle", 64'(first_v), 64'(exp_first));
    if (exp_done >= 0) check("done_cycle", 64'(done_c), 64'(exp_done));
    else check("done_seen", 64'(done_c >= 0), 64'd1);
    check("beats_consumed", 64'(beat_cnt - b0), 64'(nbeats));
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int b0, cnt;
    bit seen;
    rst = 1'b1;
    start = 1'b0;
    kernel_num = '0;
    kernel_elem = '0;
    base_addr = '0;
    wr_en = 1'b0;
    wr_col = '0;
    wr_addr = '0;
    wr_data = '0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_wr_drop", 64'(wr_drop), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_mask", 64'(out_mask), 64'd0);
    check("rst_out_fold", 64'(out_fold), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int c = 0; c < COLS; c++) begin
      for (int a = 0; a < DEPTH; a++) begin
        wr_en = 1'b1;
        wr_col = 3'(c);
        wr_addr = 8'(a);
        wr_data = pat(c, a);
        @(posedge clk);
        #1;
      end
    end
    wr_en = 1'b0;

    // 6 kernels x 9 elements, single fold
    run_stream(6, 9, 0, 2, 12, 1'b1, 1'b0);

    // kernel_elem = 0 plus a write while busy
    b0 = beat_cnt;
    kernel_num = 16'd5;
    kernel_elem = 16'd0;
    base_addr = 8'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("zero_busy_c1", 64'(busy), 64'd1);
    wr_en = 1'b1;
    wr_col = 3'd0;
    wr_addr = 8'd0;
    wr_data = 8'hEE;
    @(negedge clk);
    check("zero_done_c1", 64'(done), 64'd0);
    check("zero_valid_c1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    check("zero_done_c2", 64'(done), 64'd1);
    check("wr_drop_set", 64'(wr_drop), 64'd1);
    check("zero_busy_c2", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check("zero_no_beats", 64'(beat_cnt - b0), 64'd0);

    // 20 kernels x 4 elements: 3 folds, last fold mask 0F; start while busy ignored
    run_stream(20, 4, 0, 2, 15, 1'b0, 1'b1);
    check("wr_drop_cleared", 64'(wr_drop), 64'd0);

    // random backpressure
    rnd_mode = 1'b1;
    run_stream(20, 5, 100, 2, -1, 1'b0, 1'b0);
    rnd_mode = 1'b0;
    @(posedge clk);
    #1;

    // address wrap
    run_stream(8, 10, 250, 2, 13, 1'b0, 1'b0);

    // single beat
    run_stream(1, 1, 7, 2, 4, 1'b0, 1'b0);

    // reset after beat 3
    cnt = push_expected(20, 4, 0);
    b0 = beat_cnt;
    kernel_num = 16'd20;
    kernel_elem = 16'd4;
    base_addr = 8'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt = 0;
    while (beat_cnt - b0 < 3 && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("abort_reached_beat3", 64'(beat_cnt - b0), 64'd3);
    #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out_data", out_data, 64'd0);
    check("abort_out_mask", 64'(out_mask), 64'd0);
    check("abort_out_fold", 64'(out_fold), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || out_valid) seen = 1'b1;
    end
    check("no_done_after_abort", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    run_stream(20, 4, 0, 2, 15, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
